// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequencer for a bank of toggle flip-flops.
// This block loads the bank through an XOR pattern, then steps it up or down
// to a programmed end value. It exports the per-bit toggle vector so that
// external TFF banks can follow in lockstep.
// Optional feature: define TFF_CTRL_BACK2BACK_EN to accept a new start in the
// final RUN cycle, so that runs chain with no idle cycle between them.
module tff_count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             hold,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] load_val, end_val;
  logic             at_end;

  // Binary count toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic [WIDTH-1:0] low_mask;
    low_mask = '0;
    up_t     = '0;
    dn_t     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      low_mask = (WIDTH'(1) << i) - WIDTH'(1);
      up_t[i]  = ((count_q & low_mask) == low_mask);
      dn_t[i]  = ((~count_q & low_mask) == low_mask);
    end
  end

  // The load value comes from the live inputs. The end value comes from the latched run setup.
  assign load_val = dir ? limit : '0;
  assign end_val  = dir_q ? '0 : limit_q;
  assign at_end   = (count_q == end_val);

  // Next-state, toggle vector and handshake decode.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    t_vec   = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          t_vec   = count_q ^ load_val;
          limit_d = limit;
          dir_d   = dir;
          state_d = StRun;
        end
      end
      StRun: begin
        if (hold) begin
          // Hold freezes both stepping and the end check, so each hold cycle adds one cycle.
          t_vec = '0;
        end else if (at_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef TFF_CTRL_BACK2BACK_EN
          if (start) begin
            t_vec   = count_q ^ load_val;
            limit_d = limit;
            dir_d   = dir;
            state_d = StRun;
          end
`endif
        end else begin
          t_vec = dir_q ? dn_t : up_t;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
  end

  // State and bank mirror registers; count follows the TFF rule count ^ t_vec.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_q ^ t_vec;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench for tff_count_ctrl (WIDTH = 4). Directed vectors push the
// expected t_vec for the cycle and the expected count, busy and done after the
// next edge. A separate monitor pops each entry and compares it.
module tb_tff_count_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] limit = '0;
  logic         dir = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] t_vec;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  typedef struct {
    int           idx;
    logic         ct;
    logic [W-1:0] t;
    logic [W-1:0] c;
    logic         b;
    logic         d;
  } exp_s;

  exp_s sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .limit (limit),
    .dir   (dir),
    .hold  (hold),
    .t_vec (t_vec),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push what the DUT should show.
  task automatic cyc(input logic rs, input logic st, input logic [W-1:0] lim, input logic d,
                     input logic h, input logic ct, input logic [W-1:0] et,
                     input logic [W-1:0] ec, input logic eb, input logic ed);
    @(negedge clk);
    reset = rs;
    start = st;
    limit = lim;
    dir   = d;
    hold  = h;
    sb.push_back('{vec_idx, ct, et, ec, eb, ed});
    vec_idx++;
  endtask

  // n plain counting steps from 'from'; the expected toggle is old ^ new.
  task automatic steps(input logic [W-1:0] from, input int n, input logic d);
    logic [W-1:0] c, nxt;
    c = from;
    for (int i = 0; i < n; i++) begin
      nxt = d ? c - 4'd1 : c + 4'd1;
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, c ^ nxt, nxt, 1'b1, 1'b0);
      c = nxt;
    end
  endtask

  // Monitor: t_vec mid-cycle, registered outputs just after the edge.
  initial begin
    exp_s e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.ct) check("t_vec", e.idx, t_vec, e.t);
        @(posedge clk);
        #1;
        check("count", e.idx, count, e.c);
        check("busy", e.idx, {3'b0, busy}, {3'b0, e.b});
        check("done", e.idx, {3'b0, done}, {3'b0, e.d});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog vec %0d got timeout expected finish", vec_idx);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Up to 5. The mid-run start and limit/dir changes must be ignored.
    cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    steps(4'd0, 2, 1'b0);
    cyc(1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 4'b0001, 4'd3, 1'b1, 1'b0);
    steps(4'd3, 2, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0);

    // Down from 9, loaded from 5 with t_vec = 1100
    cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 4'b1100, 4'd9, 1'b1, 1'b0);
    steps(4'd9, 9, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);

    // Up to 15 with 3 hold cycles at 7. The end value is all-ones, so no wrap.
    cyc(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    steps(4'd0, 7, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd7, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b1111, 4'd8, 1'b1, 1'b0);
    steps(4'd8, 7, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0);

    // limit = 0: load 0 from 15, zero steps
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'b1111, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset at count = 3 of a limit = 8 run
    cyc(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    steps(4'd0, 3, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset in the end cycle drops the pending done
    cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    steps(4'd0, 1, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);

    // Start held high through the end of a limit = 2 run, with limit changed to 3 at the end
    cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'b0011, 4'd2, 1'b1, 1'b0);
`ifdef TFF_CTRL_BACK2BACK_EN
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd0, 1'b1, 1'b1);
`else
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd0, 1'b1, 1'b0);
`endif
    steps(4'd0, 3, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
